// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Multi-cycle radix-2 shift-add multiplier for the MUL / UMULL / SMULL
//   instructions. It computes one multiplier bit per cycle and then writes
//   back the low word, followed by the high word for long multiplies. The
//   write-back uses a single register-file write port.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   reset      : asynchronous, active-low reset
//   start      : multiply request; only sampled in IDLE
//   IsLongMul  : 1 = two result words (UMULL/SMULL), 0 = MUL (low word only)
//   IsSigned   : 1 = two's-complement operands; only used for long multiplies
//   SrcA, SrcB : multiplicand / multiplier, captured when start is accepted
//   busy       : high whenever the sequencer is not idle
//   WriteLo    : one-cycle strobe; ResultLo is valid for RdLo
//   WriteHi    : one-cycle strobe; ResultHi is valid for RdHi
//   done       : one-cycle pulse in the final write-back cycle
//   ResultLo   : low word of the product
//   ResultHi   : high word of the product (0 for MUL)
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             IsLongMul,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             WriteLo,
  output logic             WriteHi,
  output logic             done,
  output logic [WIDTH-1:0] ResultLo,
  output logic [WIDTH-1:0] ResultHi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] WBLO = 2'd2;
  localparam logic [1:0] WBHI = 2'd3;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]      LAST   = CW'(WIDTH);
  localparam logic [CW-1:0]      ONE_C  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  logic [1:0]         state_q,  state_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic               long_q,   long_d;
  logic               neg_q,    neg_d;
  logic [WIDTH-1:0]   resLo_q,  resLo_d;
  logic [WIDTH-1:0]   resHi_q,  resHi_d;

  logic               signedOp;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] product;

  // Signed long multiplies run on magnitudes; the sign is restored once at
  // the end. The most negative value maps onto itself, which is the correct
  // unsigned magnitude.
  assign signedOp = IsLongMul & IsSigned;
  assign magA     = (signedOp && SrcA[WIDTH-1]) ? (~SrcA + ONE_W) : SrcA;
  assign magB     = (signedOp && SrcB[WIDTH-1]) ? (~SrcB + ONE_W) : SrcB;
  assign product  = neg_q ? (~acc_q + ONE_2W) : acc_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    long_d   = long_q;
    neg_d    = neg_q;
    resLo_d  = resLo_q;
    resHi_d  = resHi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, magA};
          mplier_d = magB;
          acc_d    = '0;
          count_d  = '0;
          long_d   = IsLongMul;
          neg_d    = signedOp & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          state_d  = CALC;
        end
      end
      CALC: begin
        if (count_q != LAST) begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + ONE_C;
        end else begin
          // The extra cycle after the last step applies the sign and
          // latches the low word, so that WriteLo and ResultLo line up.
          acc_d   = product;
          resLo_d = product[WIDTH-1:0];
          if (!long_q) begin
            resHi_d = '0;
          end
          state_d = WBLO;
        end
      end
      WBLO: begin
        if (long_q) begin
          resHi_d = acc_q[2*WIDTH-1:WIDTH];
          state_d = WBHI;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      resLo_q  <= '0;
      resHi_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      long_q   <= long_d;
      neg_q    <= neg_d;
      resLo_q  <= resLo_d;
      resHi_q  <= resHi_d;
    end
  end

  // Strobes decode straight from the state, so an async reset clears them
  // in the same instant as the state register.
  assign busy     = (state_q != IDLE);
  assign WriteLo  = (state_q == WBLO);
  assign WriteHi  = (state_q == WBHI);
  assign done     = (state_q == WBHI) || ((state_q == WBLO) && !long_q);
  assign ResultLo = resLo_q;
  assign ResultHi = resHi_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer (WIDTH = 32). A cycle-level model
//   tracks each accepted operation by elapsed cycles and computes the product
//   with plain 64-bit arithmetic. A negedge process compares every DUT output
//   with that model, and directed tests add hand-computed literal checks.
module tb_mul_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         IsLongMul = 1'b0;
  logic         IsSigned = 1'b0;
  logic [W-1:0] SrcA = '0;
  logic [W-1:0] SrcB = '0;
  logic         busy;
  logic         WriteLo;
  logic         WriteHi;
  logic         done;
  logic [W-1:0] ResultLo;
  logic [W-1:0] ResultHi;

  int checks = 0;
  int errors = 0;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .IsLongMul(IsLongMul),
    .IsSigned (IsSigned),
    .SrcA     (SrcA),
    .SrcB     (SrcB),
    .busy     (busy),
    .WriteLo  (WriteLo),
    .WriteHi  (WriteHi),
    .done     (done),
    .ResultLo (ResultLo),
    .ResultHi (ResultHi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference product: sign- or zero-extend the operands to 2*W bits and multiply.
  function automatic logic [2*W-1:0] refProd(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic lng, input logic sgn);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = {{W{lng & sgn & a[W-1]}}, a};
    eb = {{W{lng & sgn & b[W-1]}}, b};
    return ea * eb;
  endfunction

  // Model: k counts the edges since the accepting edge. The low word appears at k=W+1,
  // the high word at k=W+2 for long multiplies, and the model goes idle one edge after done.
  bit             mActive = 1'b0;
  int             mK = 0;
  bit             mLong = 1'b0;
  logic [W-1:0]   mProdLo = '0;
  logic [W-1:0]   mProdHi = '0;
  logic [W-1:0]   mOutLo = '0;
  logic [W-1:0]   mOutHi = '0;
  logic [2*W-1:0] mP;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mActive = 1'b0;
      mK      = 0;
      mLong   = 1'b0;
      mOutLo  = '0;
      mOutHi  = '0;
    end else if (!mActive) begin
      if (start) begin
        mP      = refProd(SrcA, SrcB, IsLongMul, IsSigned);
        mProdLo = mP[W-1:0];
        mProdHi = mP[2*W-1:W];
        mLong   = IsLongMul;
        mActive = 1'b1;
        mK      = 0;
      end
    end else begin
      mK++;
      if (mK == W + 1) begin
        mOutLo = mProdLo;
        if (!mLong) mOutHi = '0;
      end
      if (mK == W + 2 && mLong) mOutHi = mProdHi;
      if (mK == (mLong ? W + 3 : W + 2)) mActive = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("busy",     busy,     mActive);
    check("WriteLo",  WriteLo,  mActive && mK == W + 1);
    check("WriteHi",  WriteHi,  mActive && mLong && mK == W + 2);
    check("done",     done,     mActive && mK == (mLong ? W + 2 : W + 1));
    check("ResultLo", ResultLo, mOutLo);
    check("ResultHi", ResultHi, mOutHi);
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic lng, input logic sgn);
    @(posedge clk); #2;
    SrcA = a; SrcB = b; IsLongMul = lng; IsSigned = sgn; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  // Called 2ns after the accepting edge N; checks literal results at N+W+1 and N+W+2.
  task automatic checkOutput(input string tag, input logic lng,
                             input logic [W-1:0] expLo, input logic [W-1:0] expHi);
    repeat (W + 1) @(posedge clk);
    #1;
    check({tag, ".WriteLo"},  WriteLo, 1'b1);
    check({tag, ".WriteHi0"}, WriteHi, 1'b0);
    check({tag, ".Lo"},       ResultLo, expLo);
    check({tag, ".doneLo"},   done, !lng);
    if (lng) begin
      @(posedge clk); #1;
      check({tag, ".WriteHi"},  WriteHi, 1'b1);
      check({tag, ".WriteLo0"}, WriteLo, 1'b0);
      check({tag, ".doneHi"},   done, 1'b1);
    end
    check({tag, ".Hi"}, ResultHi, expHi);
    @(posedge clk); #1;
    check({tag, ".idle"}, busy, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".idleTimeout"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [2*W-1:0] p;
    // Pin the reference function against hand-computed products.
    p = refProd(32'd7, 32'd6, 1'b0, 1'b0);
    check("ref.mul", p[W-1:0], 32'h0000002A);
    p = refProd(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("ref.umullHi", p[2*W-1:W], 32'hFFFFFFFE);
    p = refProd(32'h80000000, 32'h2, 1'b1, 1'b1);
    check("ref.smullHi", p[2*W-1:W], 32'hFFFFFFFF);
    p = refProd(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
    check("ref.smullNeg", p[W-1:0], 32'hFFFFFFF1);

    // Reset state.
    @(posedge clk); #2;
    check("rst.busy", busy, 1'b0);
    check("rst.Lo", ResultLo, '0);
    check("rst.Hi", ResultHi, '0);

    // Release reset and request in the same cycle: the first high edge accepts.
    @(posedge clk); #2;
    reset = 1'b1;
    SrcA = 32'd7; SrcB = 32'd6; IsLongMul = 1'b0; IsSigned = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    checkOutput("mul7x6", 1'b0, 32'h0000002A, 32'h0);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    checkOutput("umullMax", 1'b1, 32'h00000001, 32'hFFFFFFFE);

    applyStimulus(32'h80000000, 32'h00000002, 1'b1, 1'b1);
    checkOutput("smullMin", 1'b1, 32'h00000000, 32'hFFFFFFFF);

    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
    checkOutput("smullM1", 1'b1, 32'h00000001, 32'h00000000);

    applyStimulus(32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
    checkOutput("smullNeg", 1'b1, 32'hFFFFFFF1, 32'hFFFFFFFF);

    applyStimulus(32'hFFFFFFFF, 32'd2, 1'b0, 1'b1);
    checkOutput("mulSgnIgn", 1'b0, 32'hFFFFFFFE, 32'h0);

    // Start pulses at N+5 and N+33 and operand changes mid-operation are ignored.
    applyStimulus(32'h00010000, 32'h00030000, 1'b1, 1'b0);
    SrcA = 32'd5; SrcB = 32'd5; IsLongMul = 1'b0;
    repeat (4) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (27) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #1;
    check("ign.WriteLo", WriteLo, 1'b1);
    check("ign.Lo", ResultLo, 32'h0);
    #1 start = 1'b0;
    @(posedge clk); #1;
    check("ign.WriteHi", WriteHi, 1'b1);
    check("ign.Hi", ResultHi, 32'h00000003);
    repeat (6) begin
      @(posedge clk); #1;
      check("ign.noBusy", busy, 1'b0);
    end

    // Reset at cycle N+10 of a UMULL aborts it with all outputs cleared.
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst.busy", busy, 1'b0);
    check("arst.WriteLo", WriteLo, 1'b0);
    check("arst.WriteHi", WriteHi, 1'b0);
    check("arst.done", done, 1'b0);
    check("arst.Lo", ResultLo, '0);
    check("arst.Hi", ResultHi, '0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (W + 6) @(posedge clk);
    #1;
    check("arst.stillLo", ResultLo, '0);
    check("arst.stillBusy", busy, 1'b0);

    // Back-to-back with start held high.
    @(posedge clk); #2;
    SrcA = 32'h80000000; SrcB = 32'h2; IsLongMul = 1'b1; IsSigned = 1'b1; start = 1'b1;
    @(posedge clk); #2;
    SrcA = 32'h0000FFFF; SrcB = 32'h0000FFFF; IsLongMul = 1'b0; IsSigned = 1'b0;
    waitIdle("b2b.first");
    @(posedge clk); #1;
    check("b2b.accepted", busy, 1'b1);
    #1 start = 1'b0;
    waitIdle("b2b.second");
    check("b2b.Lo", ResultLo, 32'hFFFE0001);
    check("b2b.Hi", ResultHi, 32'h0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; all widths below are in terms of WIDTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 IsLongMul  input  1  1 = long multiply (two result words), 0 = MUL (low word only).
REQ-006 IsSigned  input  1  1 = two's-complement operands (SMULL), 0 = unsigned; ignored when IsLongMul=0.
REQ-007 SrcA  input  WIDTH  multiplicand; captured on accepted start.
REQ-008 SrcB  input  WIDTH  multiplier; captured on accepted start.
REQ-009 busy  output  1  high in every state except IDLE; the main control FSM stalls on it.
REQ-010 WriteLo  output  1  one-cycle strobe: ResultLo valid, write to RdLo.
REQ-011 WriteHi  output  1  one-cycle strobe: ResultHi valid, write to RdHi.
REQ-012 done  output  1  one-cycle pulse in the final write-back cycle.
REQ-013 ResultLo  output  WIDTH  low word of product.
REQ-014 ResultHi  output  WIDTH  high word of product (0 when IsLongMul=0).

Function
REQ-015 FSM states: IDLE, CALC, WBLO, WBHI, encoded in 2 bits.
REQ-016 IDLE: start=1 -> capture SrcA, SrcB, IsLongMul, IsSigned; load 64-bit accumulator with 0; clear step counter; go to CALC.
REQ-017 Signed capture: operands stored as magnitudes; negate flag = SrcA[WIDTH-1] XOR SrcB[WIDTH-1]; applies only when IsLongMul=1 and IsSigned=1.
REQ-018 CALC: radix-2 shift-add, one multiplier bit per cycle, LSB first; exactly WIDTH cycles; 2*WIDTH-bit accumulator, no carry loss.
REQ-019 CALC exit: after the WIDTH-th step, apply two's-complement negation to the 2*WIDTH-bit product if negate flag set; go to WBLO.
REQ-020 WBLO: WriteLo=1; ResultLo = product[WIDTH-1:0]; if IsLongMul -> WBHI, else done=1 and -> IDLE.
REQ-021 WBHI: WriteHi=1, done=1; ResultHi = product[2*WIDTH-1:WIDTH]; -> IDLE.
REQ-022 Latency: start accepted at edge N -> WriteLo at cycle N+WIDTH+1, WriteHi (long) at N+WIDTH+2; busy falls the cycle after done.
REQ-023 WriteLo and WriteHi never high in the same cycle (single register-file write port).
REQ-024 start while busy is ignored, never queued; captured operands unchanged.
REQ-025 start in the cycle done is high is ignored; accepted only from IDLE on a later edge.
REQ-026 ResultLo/ResultHi hold their last value in IDLE until the next write-back; unsigned MUL result is the low WIDTH bits of the unsigned product.
REQ-027 Input changes on SrcA/SrcB/IsLongMul/IsSigned after acceptance have no effect on the current operation.

Reset
REQ-028 reset low: state=IDLE, counter=0, accumulator=0, busy=0, WriteLo=0, WriteHi=0, done=0, ResultLo=0, ResultHi=0.
REQ-029 Reset asserted mid-CALC or mid-write-back aborts the operation; no WriteLo/WriteHi/done strobe after release for that operation.
REQ-030 First start is accepted on the first rising edge at which reset is high.

Verification
REQ-031 MUL: SrcA=7, SrcB=6, IsLongMul=0 -> ResultLo=0x0000002A with WriteLo and done in cycle N+33; WriteHi never asserted.
REQ-032 UMULL: SrcA=SrcB=0xFFFFFFFF, IsSigned=0 -> ResultLo=0x00000001 (cycle N+33), ResultHi=0xFFFFFFFE with done (cycle N+34).
REQ-033 SMULL: SrcA=0x80000000, SrcB=0x00000002 -> ResultHi=0xFFFFFFFF, ResultLo=0x00000000; also SrcA=SrcB=0xFFFFFFFF -> ResultHi=0, ResultLo=1.
REQ-034 start pulsed at cycles N+5 and N+33 during an operation -> ignored, results of the first operation unchanged, no second busy period.
REQ-035 reset low at cycle N+10 of a UMULL -> all outputs 0 asynchronously; after release no strobes until a new start.
REQ-036 Back-to-back: start held high continuously -> second operation accepted on the first edge after busy falls, results correct for both.
